// File: rtl/adc_sample_source.sv
// Sample-collection responder: scans an 8-channel 12-bit SPI ADC over the enabled channels and serves the latest result per channel.
// Optional ADC_AVG_EN: each stored sample is the 4-result average with one extra LSB of resolution.
module adc_sample_source #(
  parameter int POSITION = 243,
  parameter int CH_BASE  = 0,
  parameter int NUM_CH   = 8,
  parameter int SCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [31:0] cmd_data_in,
  input  logic        cs,
  input  logic        wr,
  input  logic [7:0]  channel_select,
  input  logic        output_sample,
  output logic [31:0] sample_data,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_mosi,
  input  logic        adc_miso
);

  localparam int DIV_W = $clog2(SCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CS_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT    = 3'd2;
  localparam logic [2:0] ST_CS_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;

  localparam logic [15:0] CMD_START = 16'd1;
  localparam logic [15:0] CMD_STOP  = 16'd2;
  localparam logic [15:0] CMD_RESET = 16'd5;

  logic [2:0]       r_state;
  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_bit;
  logic [15:0]      r_cmd;
  logic [7:0]       r_mask;
  logic             r_prime;
  logic [2:0]       r_req_ch;
  logic [2:0]       r_prev_ch;
  logic [15:0]      r_tx;
  logic [15:0]      r_rx;
  logic             r_cs_n;
  logic             r_sclk;
  logic             r_mosi;
  logic [12:0]      r_sample [8];
  logic [31:0]      r_sample_data;

  logic        w_tick;
  logic        w_bus_wr;
  logic        w_do_reset;
  logic        w_frame_end;
  logic        w_store;
  logic [2:0]  w_next_ch;
  logic [2:0]  w_rx_ch;
  logic [11:0] w_rx_data;
  logic [7:0]  w_offset;
  logic        w_claim;

  assign w_tick     = (r_div == DIV_LAST);
  assign w_bus_wr   = cs && wr && (addr[15:8] == 8'(POSITION));
  assign w_do_reset = (r_cmd == CMD_RESET);
  assign w_rx_ch    = r_rx[14:12];
  assign w_rx_data  = r_rx[11:0];

  // A returned frame is only trusted if its start bit is clear and it echoes the channel asked for one frame earlier.
  assign w_frame_end = (r_state == ST_CS_HOLD) && w_tick && !w_do_reset;
  assign w_store     = w_frame_end && !r_prime && !r_rx[15] && (w_rx_ch == r_prev_ch);

  // Round-robin pick: scanning offsets high to low leaves the nearest enabled channel above r_req_ch.
  always_comb begin
    w_next_ch = r_req_ch;
    for (int i = 8; i >= 1; i--) begin
      if (r_mask[3'(r_req_ch + 3'(i))]) begin
        w_next_ch = 3'(r_req_ch + 3'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_div     <= '0;
      r_bit     <= '0;
      r_cmd     <= '0;
      r_mask    <= '0;
      r_prime   <= 1'b1;
      r_req_ch  <= 3'd7;
      r_prev_ch <= 3'd7;
      r_tx      <= '0;
      r_rx      <= '0;
      r_cs_n    <= 1'b1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
    end else begin
      if (w_do_reset) begin
        r_state   <= ST_IDLE;
        r_div     <= '0;
        r_cmd     <= '0;
        r_mask    <= '0;
        r_prime   <= 1'b1;
        r_req_ch  <= 3'd7;
        r_prev_ch <= 3'd7;
        r_cs_n    <= 1'b1;
        r_sclk    <= 1'b0;
        r_mosi    <= 1'b0;
      end else begin
        if (r_state != ST_IDLE) begin
          r_div <= w_tick ? '0 : r_div + 1'b1;
        end
        case (r_state)
          ST_IDLE: begin
            if (r_cmd == CMD_START && r_mask != 8'd0) begin
              r_state <= ST_CS_SETUP;
              r_div   <= '0;
              r_cs_n  <= 1'b0;
              r_mosi  <= 1'b1;
            end
            r_cmd <= '0;
          end
          ST_CS_SETUP: begin
            if (w_tick) begin
              r_state   <= ST_SHIFT;
              r_bit     <= '0;
              r_req_ch  <= w_next_ch;
              r_prev_ch <= r_req_ch;
              r_tx      <= {1'b1, w_next_ch, 12'd0};
            end
          end
          ST_SHIFT: begin
            if (w_tick) begin
              if (!r_sclk) begin
                r_sclk <= 1'b1;
                r_rx   <= {r_rx[14:0], adc_miso};
              end else begin
                r_sclk <= 1'b0;
                r_tx   <= {r_tx[14:0], 1'b0};
                r_mosi <= r_tx[14];
                r_bit  <= r_bit + 1'b1;
                if (r_bit == 4'd15) begin
                  r_state <= ST_CS_HOLD;
                end
              end
            end
          end
          ST_CS_HOLD: begin
            if (w_tick) begin
              r_state <= ST_GAP;
              r_cs_n  <= 1'b1;
              r_bit   <= '0;
              r_prime <= 1'b0;
            end
          end
          ST_GAP: begin
            if (w_tick) begin
              if (r_bit == 4'd0) begin
                r_bit <= 4'd1;
              end else if (r_cmd == CMD_STOP || r_mask == 8'd0) begin
                r_state <= ST_IDLE;
                r_cmd   <= '0;
              end else begin
                r_state <= ST_CS_SETUP;
                r_cs_n  <= 1'b0;
                r_mosi  <= 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
      if (w_bus_wr && addr[7:0] == 8'd1) begin
        r_mask <= cmd_data_in[7:0];
      end
      if (w_bus_wr && addr[7:0] == 8'd2) begin
        r_cmd <= cmd_data_in[15:0];
      end
    end
  end

`ifdef ADC_AVG_EN
  logic [13:0] r_acc [8];
  logic [1:0]  r_cnt [8];
  logic [13:0] w_acc_sum;

  assign w_acc_sum = r_acc[w_rx_ch] + {2'b00, w_rx_data};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        r_sample[i] <= '0;
`ifdef ADC_AVG_EN
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
`endif
      end
    end else if (w_do_reset) begin
      for (int i = 0; i < 8; i++) begin
        r_sample[i] <= '0;
`ifdef ADC_AVG_EN
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
`endif
      end
    end else if (w_store) begin
`ifdef ADC_AVG_EN
      if (r_cnt[w_rx_ch] == 2'd3) begin
        r_sample[w_rx_ch] <= w_acc_sum[13:1];
        r_acc[w_rx_ch]    <= '0;
        r_cnt[w_rx_ch]    <= '0;
      end else begin
        r_acc[w_rx_ch] <= w_acc_sum;
        r_cnt[w_rx_ch] <= r_cnt[w_rx_ch] + 1'b1;
      end
`else
      r_sample[w_rx_ch] <= {1'b0, w_rx_data};
`endif
    end
  end

  assign w_offset = channel_select - 8'(CH_BASE);
  assign w_claim  = output_sample && ({1'b0, w_offset} < 9'(NUM_CH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sample_data <= '0;
    end else begin
      r_sample_data <= w_claim ? {19'd0, r_sample[w_offset[2:0]]} : 32'd0;
    end
  end

  assign sample_data = r_sample_data;
  assign adc_cs_n    = r_cs_n;
  assign adc_sclk    = r_sclk;
  assign adc_mosi    = r_mosi;

endmodule

// File: tb/tb_adc_sample_source.sv
// Directed bench for adc_sample_source with a behavioural SPI ADC model and expected-value queues.
module tb_adc_sample_source;
  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [31:0] cmd_data_in;
  logic        cs;
  logic        wr;
  logic [7:0]  channel_select;
  logic        output_sample;
  logic [31:0] sample_data;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_mosi;
  logic        adc_miso;

  int n_checks = 0;
  int n_errors = 0;

  adc_sample_source #(.POSITION(243), .CH_BASE(0), .NUM_CH(8), .SCLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .cmd_data_in(cmd_data_in), .cs(cs), .wr(wr),
    .channel_select(channel_select), .output_sample(output_sample), .sample_data(sample_data),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_mosi(adc_mosi), .adc_miso(adc_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC model: answers each frame with the channel requested by the previous complete frame.
  logic [11:0] m_data [8];
  logic [15:0] m_tx = '0;
  logic [15:0] m_rx = '0;
  int          m_bits = 0;
  int          m_frames = 0;
  int          m_falls = 0;
  logic [2:0]  m_prev_req = 3'd7;
  logic [2:0]  m_ret_ch = 3'd7;
  logic        m_ramp = 1'b0;
  logic [15:0] q_frame [$];
  logic [31:0] q_exp [$];

  assign adc_miso = m_tx[15];

  always @(negedge adc_cs_n) begin
    m_ret_ch = m_prev_req;
    m_tx     = {1'b0, m_prev_req, m_data[m_prev_req]};
    m_bits   = 0;
    m_falls++;
  end

  always @(negedge adc_sclk) if (adc_cs_n === 1'b0) m_tx = {m_tx[14:0], 1'b0};

  always @(posedge adc_sclk) begin
    if (adc_cs_n === 1'b0) begin
      m_rx = {m_rx[14:0], adc_mosi};
      m_bits++;
    end
  end

  always @(posedge adc_cs_n) begin
    m_frames++;
    if (m_bits == 16) begin
      if (m_ramp && m_ret_ch == 3'd1) m_data[1] = m_data[1] + 12'd1;
      m_prev_req = m_rx[14:12];
      q_frame.push_back(m_rx);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] reg_a, input logic [31:0] d);
    @(posedge clk); #1;
    cs = 1'b1; wr = 1'b1; addr = {8'd243, reg_a}; cmd_data_in = d;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0; addr = '0; cmd_data_in = '0;
  endtask

  task automatic wait_frames(input int n, input string tag);
    int target;
    int cyc;
    target = m_frames + n;
    cyc = 0;
    while (m_frames < target && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    check(tag, 32'(m_frames >= target), 32'd1);
  endtask

  task automatic wait_fall(input string tag);
    int target;
    int cyc;
    target = m_falls + 1;
    cyc = 0;
    while (m_falls < target && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    check(tag, 32'(m_falls >= target), 32'd1);
  endtask

  // Two-cycle collector strobe; expectations for the three following cycles go into q_exp.
  task automatic fetch(input string tag, input logic [7:0] ch, input logic [31:0] exp);
    @(posedge clk); #1;
    channel_select = ch; output_sample = 1'b1;
    q_exp.push_back(exp); q_exp.push_back(exp); q_exp.push_back(32'd0);
    @(posedge clk); @(negedge clk);
    check({tag, "_c1"}, sample_data, q_exp.pop_front());
    @(posedge clk); #1;
    output_sample = 1'b0; channel_select = 8'd0;
    @(negedge clk);
    check({tag, "_c2"}, sample_data, q_exp.pop_front());
    @(posedge clk); @(negedge clk);
    check({tag, "_c3"}, sample_data, q_exp.pop_front());
    $display("fetch %s ch=%0d expected=%0h", tag, ch, exp);
  endtask

  task automatic check_frame(input string tag, input logic [2:0] ch);
    logic [15:0] got;
    got = (q_frame.size() > 0) ? q_frame.pop_front() : 16'hxxxx;
    check(tag, {16'd0, got}, {16'd0, 1'b1, ch, 12'd0});
    $display("frame %s mosi=%0h", tag, got);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    logic [2:0] ret;
    for (int i = 0; i < 8; i++) m_data[i] = 12'd0;
    m_data[0] = 12'hABC; m_data[2] = 12'h123; m_data[7] = 12'h777;
    rst = 1'b1; cs = 1'b0; wr = 1'b0; addr = '0; cmd_data_in = '0;
    channel_select = '0; output_sample = 1'b0;
    #7 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sample_data", sample_data, 32'd0);
    check("rst_cs_n", {31'd0, adc_cs_n}, 32'd1);
    check("rst_sclk", {31'd0, adc_sclk}, 32'd0);
    check("rst_mosi", {31'd0, adc_mosi}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    q_frame.delete();

`ifdef ADC_AVG_EN
    m_data[1] = 12'd100; m_ramp = 1'b1;
    bus_write(8'd1, 32'h02);
    bus_write(8'd2, 32'h1);
    wait_frames(4, "avg_wait4");
    repeat (3) @(posedge clk);
    fetch("avg_before4", 8'd1, 32'd0);
    wait_frames(1, "avg_wait5");
    repeat (3) @(posedge clk);
    fetch("avg_after4", 8'd1, 32'd203);
    check_frame("avg_f1", 3'd1);
    check_frame("avg_f2", 3'd1);
    bus_write(8'd2, 32'h2);
    wait_frames(1, "avg_stop");
`else
    // Scan over channels 0 and 2; the first frame must be dropped.
    bus_write(8'd1, 32'h05);
    bus_write(8'd2, 32'h1);
    wait_frames(3, "scan_wait3");
    repeat (3) @(posedge clk);
    check_frame("frame1", 3'd0);
    check_frame("frame2", 3'd2);
    check_frame("frame3", 3'd0);
    fetch("fetch_ch2", 8'd2, 32'h0123);
    fetch("fetch_ch0", 8'd0, 32'h0ABC);
    fetch("prime_ch7", 8'd7, 32'd0);
    fetch("unclaimed_255", 8'd255, 32'd0);
    fetch("unclaimed_8", 8'd8, 32'd0);

    // STOP mid-SHIFT: frame completes and is stored, then no further frames.
    wait_frames(1, "stop_sync");
    m_data[0] = 12'h111; m_data[2] = 12'h222;
    wait_fall("stop_fall");
    repeat (40) @(posedge clk);
    bus_write(8'd2, 32'h2);
    wait_frames(1, "stop_done");
    ret = m_ret_ch;
    f0 = m_falls;
    repeat (400) @(posedge clk);
    @(negedge clk);
    check("stop_no_restart", 32'(m_falls - f0), 32'd0);
    check("stop_sclk_idle", {31'd0, adc_sclk}, 32'd0);
    fetch("stop_stored", {5'd0, ret}, {20'd0, m_data[ret]});
    q_frame.delete();

    // RESET command after 7 sclk rising edges of a fresh frame.
    bus_write(8'd2, 32'h1);
    wait_fall("reset_fall");
    begin
      int cyc;
      cyc = 0;
      while (m_bits < 7 && cyc < 1000) begin
        @(posedge clk);
        cyc++;
      end
      check("reset_sync", 32'(m_bits == 7), 32'd1);
    end
    #1;
    cs = 1'b1; wr = 1'b1; addr = {8'd243, 8'd2}; cmd_data_in = 32'h5;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0; addr = '0; cmd_data_in = '0;
    @(posedge clk); @(negedge clk);
    check("reset_cs_n", {31'd0, adc_cs_n}, 32'd1);
    check("reset_sclk", {31'd0, adc_sclk}, 32'd0);
    fetch("reset_ch0", 8'd0, 32'd0);
    fetch("reset_ch2", 8'd2, 32'd0);
    f0 = m_falls;
    bus_write(8'd2, 32'h1);
    repeat (100) @(posedge clk);
    check("start_mask0_ignored", 32'(m_falls - f0), 32'd0);
    bus_write(8'd1, 32'h05);
    bus_write(8'd2, 32'h1);
    wait_frames(1, "reprime_f1");
    ret = m_ret_ch;
    repeat (3) @(posedge clk);
    fetch("reprime_discard", {5'd0, ret}, 32'd0);
    wait_frames(1, "reprime_f2");
    repeat (3) @(posedge clk);
    fetch("reprime_store_ch0", 8'd0, {20'd0, m_data[0]});
    bus_write(8'd2, 32'h2);
    wait_frames(1, "final_stop");
`endif
    repeat (20) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/adc_sample_source.md
Name: adc_sample_source

Overview:
Responder on the sample-collection interface. Continuously runs a 16-bit SPI ADC (8 channels, 12-bit) over its enabled channels and keeps the latest result per channel. When the sample collector strobes output_sample with a channel_select in this block's range, the block drives that channel's result onto sample_data. It sits beside the other collection units, and its sample_data is OR-combined into the collector's input.

Parameters:
POSITION, 243, command-bus slot; matches addr[15:8]
CH_BASE, 0, channel_select value mapped to local ADC channel 0
NUM_CH, 8, local ADC channels; channel_select CH_BASE..CH_BASE+NUM_CH-1 is claimed
SCLK_DIV, 4, clk cycles per SPI half-period (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
addr  in  16  command bus address
cmd_data_in  in  32  command bus write data
cs  in  1  command bus select
wr  in  1  command bus write strobe, 1 cycle
channel_select  in  8  channel requested by the collector
output_sample  in  1  collector fetch strobe
sample_data  out  32  selected sample; 0 when not claimed
adc_cs_n  out  1  SPI chip select
adc_sclk  out  1  SPI clock, idle low
adc_mosi  out  1  SPI data to ADC
adc_miso  in  1  SPI data from ADC

Behaviour:
- Reset (rst=0, async) sets: sample_data=0, adc_cs_n=1, adc_sclk=0, adc_mosi=0, enable mask=0, all 8 sample regs=0, FSM=IDLE, prime flag set.
- Command bus: a write is accepted when cs & wr & addr[15:8]==POSITION.
  - addr[7:0]=1: enable mask <= cmd_data_in[7:0].
  - addr[7:0]=2: command <= cmd_data_in[15:0]. Command codes: 1 START, 2 STOP, 5 RESET.
- FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP.
  - IDLE -> CS_SETUP on START when mask!=0. START with mask=0 is ignored and cleared.
  - CS_SETUP: adc_cs_n=0 for 1 half-period. During this state, latch next_ch, the lowest enabled channel above the previous channel, wrapping.
  - SHIFT: 16 sclk periods, MSB first. MOSI frame = {1'b1, next_ch[2:0], 12'b0}. MOSI changes on sclk falling edge (bit 15 is presented at CS_SETUP entry). MISO is sampled on sclk rising edge.
  - CS_HOLD: 1 half-period, then adc_cs_n=1.
  - GAP: 2 half-periods, adc_cs_n high. Store the result here.
  - Leaving GAP: STOP pending -> IDLE and clear command; otherwise -> CS_SETUP.
- Result pipeline: MISO frame = {1'b0, ch[2:0], data[11:0]}. The frame returns the channel requested by the previous frame.
  - First frame after START has the prime flag set: its result is discarded and the flag is cleared.
  - Otherwise sample_reg[ch] <= {19'b0, 1'b0, data[11:0]}, with ch taken from the frame.
  - If the frame's ch differs from the previously requested channel, discard the result (count in debug).
- Mask change mid-frame: takes effect at the next next_ch choice. If mask becomes 0, finish the frame, store it, then go to IDLE.
- RESET command, any state: at the next clk, abort the frame (adc_cs_n=1, adc_sclk=0), clear all sample regs and the mask, set prime, go to IDLE, clear command.
- Responder handshake: claimed = output_sample & (channel_select - CH_BASE) < NUM_CH.
  - Each cycle: sample_data <= claimed ? sample_reg[channel_select-CH_BASE] : 0.
  - Latency 1 clk. The collector asserts output_sample for 2 cycles, so data is valid on the second cycle and on the cycle after.
  - A store to the same sample_reg in the same cycle: the old value is driven; the new value appears on the next claimed cycle.
  - A disabled but claimed channel returns its last stored value. channel_select 255 is never claimed.

Optional Feature:
ADC_AVG_EN
- Defined: each channel accumulates 4 valid results in a 14-bit accumulator, plus a 2-bit count per channel. On the 4th result, sample_reg[ch][12:0] <= acc>>1 (13-bit, extra LSB of resolution), and acc and count clear. The RESET command and rst clear the accumulators.
- Undefined: no accumulators. Every valid result is stored directly as {1'b0, data}.

Test Plan:
- Reset, mask=8'h05, START, ADC model returns 12'hABC for ch0 and 12'h123 for ch2 -> MOSI channel sequence 0,2,0,2…; first result dropped; sample_reg0=32'h0ABC, sample_reg2=32'h0123.
- Collector fetch: channel_select=CH_BASE+2, output_sample for 2 cycles -> sample_data=32'h0123 from the cycle after the first strobe, for 2 cycles; then 0.
- channel_select=255 or CH_BASE+8 with output_sample=1 -> sample_data stays 0.
- STOP mid-SHIFT -> frame completes (16 sclk, adc_cs_n rises), result stored, FSM IDLE, no further adc_cs_n falling edge.
- RESET command mid-SHIFT after 7 sclk -> next clk adc_cs_n=1 and adc_sclk=0; all sample regs read back 0; new START discards the first frame.
- ADC_AVG_EN defined, ch1 returns 100, 101, 102, 103 -> sample_reg1 unchanged until the 4th result, then 13'd203.
